// File: rtl/riscvibe_pkg.sv
// riscvibe_pkg: shared hazard-controller FSM state type and load-use detection helper.
package riscvibe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      EX_WAIT  = 2'd2
   } hazard_state_t;

   localparam int REG_AW = 5;

   function automatic logic load_use_hit(
      input logic              ex_valid,
      input logic              ex_mem_read,
      input logic [REG_AW-1:0] ex_rd,
      input logic              id_valid,
      input logic              uses_rs1,
      input logic [REG_AW-1:0] rs1,
      input logic              uses_rs2,
      input logic [REG_AW-1:0] rs2
   );
      return ex_valid && ex_mem_read && id_valid && ex_rd != '0 &&
             ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating counters of stall cycles and front-end flush cycles.
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
         if (flush && !(&flush_count)) flush_count <= flush_count + 32'd1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect control for a 5-stage pipeline with memory and multi-cycle waits.
// Defining HAZARD_PERF_EN adds saturating perf counter outputs.
module pipeline_hazard_ctrl
   import riscvibe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_ex_rd_addr,
   input  logic              id_ex_mem_read,
   input  logic              id_ex_valid,
   input  logic              ex_branch_taken,
   input  logic              ex_mc_start,
   input  logic              ex_mc_done,
   input  logic              dmem_req,
   input  logic              dmem_ack,
   output logic              stall_if,
   output logic              stall_id,
   output logic              stall_ex,
   output logic              stall_mem,
   output logic              flush_id,
   output logic              flush_ex,
   output logic              flush_mem,
   output logic              flush_wb,
   output logic              redirect_en,
   output logic [1:0]        ctrl_state
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_flush_count
`endif
);

   hazard_state_t state, st;
   logic br_pend, lu_prev;
   logic mem_pend, mem_wait, ex_wait, busy, br, do_br, do_lu, lu;

   // the unused encoding 3 falls back to RUN
   assign st       = (state == MEM_WAIT || state == EX_WAIT) ? state : RUN;
   assign mem_pend = dmem_req && !dmem_ack;
   assign mem_wait = st == MEM_WAIT || (st == RUN && mem_pend);
   assign ex_wait  = st == EX_WAIT;
   assign busy     = mem_wait || ex_wait;
   assign br       = ex_branch_taken || br_pend;
   assign lu       = load_use_hit(id_ex_valid, id_ex_mem_read, id_ex_rd_addr, id_valid,
                                  id_uses_rs1, id_rs1_addr, id_uses_rs2, id_rs2_addr);
   assign do_br    = !busy && br;
   assign do_lu    = !busy && !br && lu && !lu_prev;

   always_comb begin
      stall_if    = rst_n && (busy || do_lu);
      stall_id    = rst_n && (busy || do_lu);
      stall_ex    = rst_n && busy;
      stall_mem   = rst_n && (mem_wait || (ex_wait && mem_pend));
      flush_id    = rst_n && do_br;
      flush_ex    = rst_n && (do_br || do_lu);
      flush_mem   = rst_n && ex_wait;
      flush_wb    = rst_n && (mem_wait || (ex_wait && mem_pend));
      redirect_en = rst_n && do_br;
      ctrl_state  = st;
   end

   // a branch seen while waiting is held until the first free RUN cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= RUN;
         br_pend <= 1'b0;
         lu_prev <= 1'b0;
      end else begin
         state   <= (st == RUN)      ? (mem_pend ? MEM_WAIT : (ex_mc_start && !ex_mc_done) ? EX_WAIT : RUN) :
                    (st == MEM_WAIT) ? (dmem_ack ? RUN : MEM_WAIT) :
                                       ((ex_mc_done && !mem_pend) ? RUN : EX_WAIT);
         br_pend <= busy && br;
         lu_prev <= do_lu;
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt u_perf (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (busy || do_lu),
      .flush        (do_br || do_lu),
      .stall_cycles (perf_stall_cycles),
      .flush_count  (perf_flush_count)
   );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized hazard scenarios against a behavioural model via a scoreboard.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] id_rs1_addr, id_rs2_addr, id_ex_rd_addr;
   logic id_uses_rs1, id_uses_rs2, id_valid, id_ex_mem_read, id_ex_valid;
   logic ex_branch_taken, ex_mc_start, ex_mc_done, dmem_req, dmem_ack;
   logic stall_if, stall_id, stall_ex, stall_mem;
   logic flush_id, flush_ex, flush_mem, flush_wb, redirect_en;
   logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

   always #5 clk = ~clk;

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .id_valid        (id_valid),
      .id_ex_rd_addr   (id_ex_rd_addr),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_valid     (id_ex_valid),
      .ex_branch_taken (ex_branch_taken),
      .ex_mc_start     (ex_mc_start),
      .ex_mc_done      (ex_mc_done),
      .dmem_req        (dmem_req),
      .dmem_ack        (dmem_ack),
      .stall_if        (stall_if),
      .stall_id        (stall_id),
      .stall_ex        (stall_ex),
      .stall_mem       (stall_mem),
      .flush_id        (flush_id),
      .flush_ex        (flush_ex),
      .flush_mem       (flush_mem),
      .flush_wb        (flush_wb),
      .redirect_en     (redirect_en),
      .ctrl_state      (ctrl_state)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flush_count  (perf_flush_count)
`endif
   );

   typedef struct {
      logic [10:0] o;
`ifdef HAZARD_PERF_EN
      logic [31:0] ps;
      logic [31:0] pf;
`endif
   } exp_t;

   exp_t q[$];
   int passed = 0;
   int total  = 0;

   // model: 0 = running, 1 = waiting on memory, 2 = waiting on multi-cycle EX op
   int ms;
   bit owed, lu_last;
`ifdef HAZARD_PERF_EN
   logic [31:0] ps, pf;
`endif

   function automatic logic [10:0] outs();
      return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb,
              redirect_en, ctrl_state};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
   endtask

   task automatic model_reset();
      ms = 0; owed = 0; lu_last = 0;
`ifdef HAZARD_PERF_EN
      ps = 0; pf = 0;
`endif
   endtask

   task automatic idle();
      id_rs1_addr = 0; id_rs2_addr = 0; id_ex_rd_addr = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; id_valid = 0; id_ex_mem_read = 0; id_ex_valid = 0;
      ex_branch_taken = 0; ex_mc_start = 0; ex_mc_done = 0; dmem_req = 0; dmem_ack = 0;
   endtask

   task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1);
      id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd_addr = rd;
      id_valid = 1; id_uses_rs1 = 1; id_rs1_addr = rs1;
   endtask

   // expectation for the current inputs, then advance the model one clock
   task automatic step();
      exp_t e;
      logic [8:0] b;
      bit pend, br, lu, waiting, lus;
      pend = dmem_req && !dmem_ack;
      br = ex_branch_taken || owed;
      lu = id_ex_valid && id_ex_mem_read && id_valid && id_ex_rd_addr != 0 &&
           ((id_uses_rs1 && id_rs1_addr == id_ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == id_ex_rd_addr));
      waiting = ms != 0 || pend;
      lus = 0;
      if (ms == 1 || (ms == 0 && pend)) b = 9'b1111_0001_0;
      else if (ms == 2) b = {3'b111, pend, 3'b001, pend, 1'b0};
      else if (br) b = 9'b0000_1100_1;
      else if (lu && !lu_last) begin b = 9'b1100_0100_0; lus = 1; end
      else b = '0;
      e.o = {b, 2'(ms)};
`ifdef HAZARD_PERF_EN
      e.ps = ps; e.pf = pf;
      if (b[8]) ps++;
      if (b[4] || b[3]) pf++;
`endif
      q.push_back(e);
      owed = waiting && br;
      lu_last = lus;
      if (ms == 0) ms = pend ? 1 : (ex_mc_start && !ex_mc_done) ? 2 : 0;
      else if (ms == 1) ms = dmem_ack ? 0 : 1;
      else ms = (ex_mc_done && !pend) ? 0 : 2;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("outputs", 32'(outs()), 32'(e.o));
`ifdef HAZARD_PERF_EN
         chk("perf_stall_cycles", perf_stall_cycles, e.ps);
         chk("perf_flush_count", perf_flush_count, e.pf);
`endif
      end
   end

   initial begin
      idle();
      rst_n = 0;
      model_reset();
      #3;
      chk("reset_outputs", 32'(outs()), 32'd0);
      #9 rst_n = 1;
      @(posedge clk);
      #1;

      load_use(5'd5, 5'd5); step(); step();
      idle(); step();
      load_use(5'd0, 5'd0); step();
      idle(); dmem_req = 1; step(); step(); step();
      dmem_ack = 1; step();
      idle(); step();
      load_use(5'd7, 5'd7); ex_branch_taken = 1; step();
      idle(); ex_mc_start = 1; step();
      ex_mc_start = 0; ex_branch_taken = 1; step(); step(); step();
      ex_mc_done = 1; step();
      idle(); step(); step();
      ex_mc_start = 1; dmem_req = 1; step();
      ex_mc_start = 1; dmem_ack = 1; step();
      idle(); ex_mc_done = 1; step();

      idle(); dmem_req = 1; step(); step();
      #2 rst_n = 0;
      #1;
      chk("async_reset_outputs", 32'(outs()), 32'd0);
`ifdef HAZARD_PERF_EN
      chk("async_reset_perf", perf_stall_cycles | perf_flush_count, 32'd0);
`endif
      @(posedge clk);
      #1;
      chk("reset_held_outputs", 32'(outs()), 32'd0);
      #2 rst_n = 1;
      model_reset();
      step();
      dmem_ack = 1; step();
      idle(); step();

      for (int i = 0; i < 3000; i++) begin
         id_rs1_addr     = 5'($urandom_range(0, 3));
         id_rs2_addr     = 5'($urandom_range(0, 3));
         id_ex_rd_addr   = 5'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom_range(0, 1));
         id_uses_rs2     = 1'($urandom_range(0, 1));
         id_valid        = $urandom_range(0, 9) < 8;
         id_ex_valid     = $urandom_range(0, 9) < 7;
         id_ex_mem_read  = $urandom_range(0, 1) == 1;
         ex_branch_taken = $urandom_range(0, 99) < 15;
         ex_mc_start     = $urandom_range(0, 99) < 15;
         ex_mc_done      = $urandom_range(0, 99) < 30;
         dmem_req        = $urandom_range(0, 99) < 25;
         dmem_ack        = $urandom_range(0, 1) == 1;
         step();
      end
      idle();
      @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  pipeline clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have: id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have: id_uses_rs1, id_uses_rs2, id_valid  in  1 each  source-use qualifiers for ID.
REQ-005 SHALL have: id_ex_rd_addr  in  5; id_ex_mem_read, id_ex_valid  in  1 each  describe the load in EX.
REQ-006 SHALL have: ex_branch_taken  in  1  resolved taken branch/jump in EX.
REQ-007 SHALL have: ex_mc_start, ex_mc_done  in  1 each  multi-cycle EX op start / completion.
REQ-008 SHALL have: dmem_req, dmem_ack  in  1 each  MEM-stage data memory handshake.
REQ-009 SHALL have: stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC or the named stage register.
REQ-010 SHALL have: flush_id, flush_ex, flush_mem, flush_wb  out  1 each  bubble into IF/ID, ID/EX, EX/MEM, MEM/WB.
REQ-011 SHALL have: redirect_en  out  1  PC redirect permitted this cycle.
REQ-012 SHALL have: ctrl_state  out  2  current FSM state.

Function
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1, EX_WAIT=2; encoding 3 is unreachable and SHALL decode as RUN.
REQ-014 RUN->MEM_WAIT SHALL occur when dmem_req && !dmem_ack; MEM_WAIT->RUN SHALL occur on the cycle dmem_ack=1 is sampled.
REQ-015 RUN->EX_WAIT SHALL occur when ex_mc_start && !ex_mc_done, with no MEM wait pending; EX_WAIT->RUN SHALL occur on the cycle ex_mc_done=1 is sampled.
REQ-016 Both waits pending in RUN: the FSM SHALL enter MEM_WAIT and SHALL re-evaluate ex_mc_start after returning to RUN.
REQ-017 While MEM wait is active (MEM_WAIT, or RUN with dmem_req && !dmem_ack): all four stall_* SHALL be 1, flush_wb SHALL be 1, all other flushes SHALL be 0, and redirect_en SHALL be 0.
REQ-018 EX_WAIT: stall_if, stall_id, stall_ex and flush_mem SHALL be 1 and redirect_en SHALL be 0; if dmem_req && !dmem_ack also holds, stall_mem and flush_wb SHALL additionally be 1 and the state SHALL NOT change.
REQ-019 Branch with no wait active: redirect_en, flush_id and flush_ex SHALL be 1; a taken branch seen during a wait SHALL take effect in the first RUN cycle after the wait.
REQ-020 Load-use condition: id_ex_valid && id_ex_mem_read && id_valid && id_ex_rd_addr!=0 && ((id_uses_rs1 && id_rs1_addr==id_ex_rd_addr) || (id_uses_rs2 && id_rs2_addr==id_ex_rd_addr)).
REQ-021 Load-use with no wait and no branch: stall_if, stall_id and flush_ex SHALL be 1 for exactly one cycle.
REQ-022 Priority SHALL be: MEM wait > EX wait > branch > load-use; a branch cancels a coincident load-use stall.
REQ-023 Outputs SHALL be combinational from the registered state and current inputs, with zero added latency.

Reset
REQ-024 rst_n=0 SHALL force state RUN immediately, with no clock edge required.
REQ-025 While rst_n=0, all stall_*, flush_* and redirect_en SHALL be 0.
REQ-026 Reset asserted mid-wait SHALL abandon the wait; after release the FSM SHALL re-evaluate inputs from RUN.

Configuration
REQ-027 With HAZARD_PERF_EN defined, the block SHALL add outputs perf_stall_cycles (32) and perf_flush_count (32).
REQ-028 perf_stall_cycles SHALL increment on any cycle with stall_if=1.
REQ-029 perf_flush_count SHALL increment on any cycle with flush_id or flush_ex =1.
REQ-030 Both perf counters SHALL reset to 0 and SHALL saturate at 0xFFFFFFFF.
REQ-031 Without HAZARD_PERF_EN, the perf ports and counter logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Typedef hazard_state_t (2-bit enum) and the state constants SHALL live in riscvibe_pkg.
REQ-033 The perf counters SHALL be sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_EN.

Verification
REQ-034 Load-use: EX = lw x5 (rd=5, mem_read=1), ID rs1=5 with uses_rs1=1 -> one cycle of stall_if=stall_id=flush_ex=1, then all 0.
REQ-035 Load x0: the same stimulus with rd=0 -> no stall.
REQ-036 MEM wait: dmem_req=1 with dmem_ack low for 3 cycles -> ctrl_state=1, all stalls and flush_wb high through the ack cycle; ctrl_state=0 on the next cycle.
REQ-037 Branch plus load-use in the same cycle -> flush_id=flush_ex=redirect_en=1, stall_if=0.
REQ-038 Branch during EX_WAIT (ex_mc_done after 4 cycles) -> redirect_en=0 throughout, then 1 in the first RUN cycle.
REQ-039 rst_n pulled low in MEM_WAIT -> ctrl_state=0 and all outputs 0 asynchronously; with HAZARD_PERF_EN, counters read 0.
